// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and counter saturation limit.
package period_meter_pkg;

  localparam int unsigned MIN_CNT_W       = 4;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TIMEOUT = 2'd2
  } pm_state_t;

  // Largest count held before timing out (2^w - 2), so cnt + 1 never wraps.
  function automatic logic [63:0] sat_count(input int unsigned w);
    logic [64:0] pow2;
    pow2 = 65'(1) << w;
    return 64'(pow2 - 65'd2);
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchronizes an asynchronous input and emits registered single-cycle rise/fall strobes.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic fsys,
  input  logic pm_rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   seen_low_q;

  // A rise is only honoured once a genuine low has passed through the chain,
  // so an input already high at reset release is not mistaken for an edge.
  always_ff @(posedge fsys) begin
    if (pm_rst) begin
      sync_q     <= '0;
      fill_q     <= '0;
      prev_q     <= 1'b0;
      seen_low_q <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
        seen_low_q <= 1'b1;
      end
      rise <= sync_q[SYNC_STAGES-1] & ~prev_q & seen_low_q;
      fall <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous input in fsys cycles,
// presenting results through a valid/ready handshake with sticky timeout/overrun flags.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             fsys,
  input  logic             pm_rst,
  input  logic             pm_in,
  input  logic             pm_ready,
  output logic [CNT_W-1:0] pm_period,
  output logic [CNT_W-1:0] pm_high,
  output logic             pm_valid,
  output logic             pm_timeout,
  output logic             pm_overrun
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_count(CNT_W));

  if (CNT_W < MIN_CNT_W) begin : g_cnt_w_chk
    $error("period_meter: CNT_W below minimum");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_sync_chk
    $error("period_meter: SYNC_STAGES below minimum");
  end

  logic             rise;
  logic             fall;
  pm_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cap;
  logic             high_seen;

  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] meas_high_c;
  logic             accept_c;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .fsys  (fsys),
    .pm_rst(pm_rst),
    .din   (pm_in),
    .rise  (rise),
    .fall  (fall)
  );

  // A period with no captured fall reports the whole period as high time.
  assign cnt_inc_c   = cnt + CNT_W'(1);
  assign meas_high_c = high_seen ? high_cap : cnt_inc_c;
  assign accept_c    = !pm_valid || pm_ready;

  always_ff @(posedge fsys) begin
    if (pm_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      high_cap   <= '0;
      high_seen  <= 1'b0;
      pm_period  <= '0;
      pm_high    <= '0;
      pm_valid   <= 1'b0;
      pm_timeout <= 1'b0;
      pm_overrun <= 1'b0;
    end else begin
      if (pm_valid && pm_ready) begin
        pm_valid <= 1'b0;
      end
      unique case (state)
        IDLE, TIMEOUT: begin
          if (rise) begin
            cnt       <= '0;
            high_seen <= 1'b0;
            state     <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            cnt       <= '0;
            high_seen <= 1'b0;
            if (accept_c) begin
              pm_period <= cnt_inc_c;
              pm_high   <= meas_high_c;
              pm_valid  <= 1'b1;
            end else begin
              pm_overrun <= 1'b1;
            end
          end else begin
            if (fall && !high_seen) begin
              high_cap  <= cnt_inc_c;
              high_seen <= 1'b1;
            end
            // Saturate instead of wrapping; the partial period is abandoned.
            if (cnt == CNT_SAT) begin
              pm_timeout <= 1'b1;
              state      <= TIMEOUT;
            end else begin
              cnt <= cnt_inc_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a 32-bit instance for the main scenarios, a 4-bit one for timeout.
module tb_period_meter;

  localparam int unsigned W  = 32;
  localparam int unsigned W4 = 4;

  typedef struct {
    logic [31:0] period;
    logic [31:0] high;
  } res_t;

  logic          fsys = 1'b0;
  logic          pm_rst;
  logic          pm_in;
  logic          pm_in4;
  logic          pm_ready;
  logic [W-1:0]  pm_period;
  logic [W-1:0]  pm_high;
  logic          pm_valid;
  logic          pm_timeout;
  logic          pm_overrun;
  logic [W4-1:0] p4_period;
  logic [W4-1:0] p4_high;
  logic          p4_valid;
  logic          p4_timeout;
  logic          p4_overrun;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  res_t        sb[$];
  res_t        sb4[$];
  res_t        exp_r;
  res_t        exp4_r;

  period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .fsys(fsys), .pm_rst(pm_rst), .pm_in(pm_in), .pm_ready(pm_ready),
    .pm_period(pm_period), .pm_high(pm_high), .pm_valid(pm_valid),
    .pm_timeout(pm_timeout), .pm_overrun(pm_overrun)
  );

  period_meter #(.CNT_W(W4), .SYNC_STAGES(2)) dut4 (
    .fsys(fsys), .pm_rst(pm_rst), .pm_in(pm_in4), .pm_ready(pm_ready),
    .pm_period(p4_period), .pm_high(p4_high), .pm_valid(p4_valid),
    .pm_timeout(p4_timeout), .pm_overrun(p4_overrun)
  );

  always #5 fsys = ~fsys;

  // Each accepted result of the 32-bit meter is popped and compared.
  always @(negedge fsys) begin
    if (!pm_rst && pm_valid && pm_ready) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL result32_unexpected: got period=%0d high=%0d, required no result", pm_period, pm_high);
      end else begin
        exp_r = sb.pop_front();
        if (pm_period !== exp_r.period || pm_high !== exp_r.high)
          $display("FAIL result32: got period=%0d high=%0d, required period=%0d high=%0d",
                   pm_period, pm_high, exp_r.period, exp_r.high);
        else pass_cnt++;
      end
    end
  end

  always @(negedge fsys) begin
    if (!pm_rst && p4_valid && pm_ready) begin
      chk_cnt++;
      if (sb4.size() == 0) begin
        $display("FAIL result4_unexpected: got period=%0d high=%0d, required no result", p4_period, p4_high);
      end else begin
        exp4_r = sb4.pop_front();
        if (32'(p4_period) !== exp4_r.period || 32'(p4_high) !== exp4_r.high)
          $display("FAIL result4: got period=%0d high=%0d, required period=%0d high=%0d",
                   p4_period, p4_high, exp4_r.period, exp4_r.high);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required completion within time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fsys);
    #1;
  endtask

  task automatic do_reset();
    pm_rst = 1'b1;
    tick(2);
    pm_rst = 1'b0;
  endtask

  // n cycles of hi/lo; rises with index >= first_push produce an expected result of hi+lo/hi.
  task automatic wave(input int hi, input int lo, input int n, input int first_push, input bit use4);
    for (int i = 0; i < n; i++) begin
      if (i >= first_push) begin
        if (use4) sb4.push_back('{32'(hi + lo), 32'(hi)});
        else      sb.push_back('{32'(hi + lo), 32'(hi)});
      end
      if (use4) pm_in4 = 1'b1; else pm_in = 1'b1;
      tick(hi);
      if (use4) pm_in4 = 1'b0; else pm_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic test_reset();
    pm_rst = 1'b1;
    tick(2);
    chk_cnt++;
    if (pm_period !== '0) $display("FAIL reset_period: got %0d required 0", pm_period); else pass_cnt++;
    chk_cnt++;
    if (pm_high !== '0) $display("FAIL reset_high: got %0d required 0", pm_high); else pass_cnt++;
    chk_cnt++;
    if ({pm_valid, pm_timeout, pm_overrun} !== 3'b000)
      $display("FAIL reset_flags: got %b required 000", {pm_valid, pm_timeout, pm_overrun});
    else pass_cnt++;
    chk_cnt++;
    if ({p4_valid, p4_timeout, p4_overrun, p4_period, p4_high} !== 11'd0)
      $display("FAIL reset_dut4: got %b required 0", {p4_valid, p4_timeout, p4_overrun, p4_period, p4_high});
    else pass_cnt++;
    pm_rst = 1'b0;
    tick(4);
  endtask

  task automatic test_div16();
    pm_ready = 1'b1;
    do_reset();
    tick(4);
    wave(8, 8, 5, 1, 1'b0);
    tick(8);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL div16_pending: got %0d outstanding required 0", sb.size()); else pass_cnt++;
    chk_cnt++;
    if ({pm_timeout, pm_overrun} !== 2'b00)
      $display("FAIL div16_flags: got %b required 00", {pm_timeout, pm_overrun});
    else pass_cnt++;
  endtask

  task automatic test_pulse();
    pm_ready = 1'b1;
    do_reset();
    tick(4);
    wave(3, 7, 5, 1, 1'b0);
    tick(8);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL pulse_pending: got %0d outstanding required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_overrun();
    pm_ready = 1'b0;
    do_reset();
    tick(4);
    wave(8, 8, 2, 1, 1'b0);
    wave(8, 8, 1, 1, 1'b0);
    chk_cnt++;
    if (pm_valid !== 1'b1) $display("FAIL overrun_valid_held: got %b required 1", pm_valid); else pass_cnt++;
    chk_cnt++;
    if (pm_overrun !== 1'b1) $display("FAIL overrun_flag: got %b required 1", pm_overrun); else pass_cnt++;
    chk_cnt++;
    if (pm_period !== 32'd16 || pm_high !== 32'd8)
      $display("FAIL overrun_held_result: got %0d/%0d required 16/8", pm_period, pm_high);
    else pass_cnt++;
    pm_ready = 1'b1;
    tick(1);
    chk_cnt++;
    if (pm_valid !== 1'b0) $display("FAIL overrun_valid_drop: got %b required 0", pm_valid); else pass_cnt++;
    // One cycle spent on the handshake stretches this low phase to 9 cycles.
    sb.push_back('{32'd17, 32'd8});
    wave(8, 8, 1, 1, 1'b0);
    tick(8);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL overrun_pending: got %0d outstanding required 0", sb.size()); else pass_cnt++;
    chk_cnt++;
    if (pm_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b required 1", pm_overrun); else pass_cnt++;
  endtask

  task automatic test_timeout();
    pm_ready = 1'b1;
    do_reset();
    tick(4);
    pm_in4 = 1'b1;
    tick(3);
    pm_in4 = 1'b0;
    tick(15);
    chk_cnt++;
    if (p4_timeout !== 1'b0) $display("FAIL timeout_early: got %b required 0", p4_timeout); else pass_cnt++;
    tick(1);
    chk_cnt++;
    if (p4_timeout !== 1'b1) $display("FAIL timeout_set: got %b required 1", p4_timeout); else pass_cnt++;
    chk_cnt++;
    if (p4_valid !== 1'b0) $display("FAIL timeout_no_result: got %b required 0", p4_valid); else pass_cnt++;
    wave(3, 4, 2, 1, 1'b1);
    tick(8);
    chk_cnt++;
    if (sb4.size() != 0) $display("FAIL timeout_pending: got %0d outstanding required 0", sb4.size()); else pass_cnt++;
    chk_cnt++;
    if (p4_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", p4_timeout); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    pm_ready = 1'b0;
    do_reset();
    tick(4);
    wave(8, 8, 2, 99, 1'b0);
    pm_in = 1'b1;
    tick(4);
    chk_cnt++;
    if (pm_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b required 1", pm_valid); else pass_cnt++;
    pm_rst = 1'b1;
    tick(1);
    pm_rst = 1'b0;
    chk_cnt++;
    if (pm_period !== '0 || pm_high !== '0)
      $display("FAIL rstmid_result: got %0d/%0d required 0/0", pm_period, pm_high);
    else pass_cnt++;
    chk_cnt++;
    if ({pm_valid, pm_timeout, pm_overrun} !== 3'b000)
      $display("FAIL rstmid_flags: got %b required 000", {pm_valid, pm_timeout, pm_overrun});
    else pass_cnt++;
    pm_ready = 1'b1;
    tick(6);
    pm_in = 1'b0;
    tick(8);
    wave(8, 8, 3, 1, 1'b0);
    tick(8);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL rstmid_pending: got %0d outstanding required 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_hold_high();
    pm_ready = 1'b1;
    pm_in    = 1'b1;
    do_reset();
    tick(20);
    chk_cnt++;
    if (pm_valid !== 1'b0) $display("FAIL hold_no_result: got %b required 0", pm_valid); else pass_cnt++;
    pm_in = 1'b0;
    tick(8);
    wave(8, 8, 2, 1, 1'b0);
    tick(8);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL hold_pending: got %0d outstanding required 0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    pm_rst   = 1'b1;
    pm_in    = 1'b0;
    pm_in4   = 1'b0;
    pm_ready = 1'b1;
    test_reset();
    test_div16();
    test_pulse();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_hold_high();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of the period and high-time counters and results, minimum 4.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pm_in, minimum 2.
REQ-003 fsys  input  1  system clock; all logic on its rising edge; one clock only.
REQ-004 pm_rst  input  1  reset, synchronous, active-high.
REQ-005 pm_in  input  1  measured signal, asynchronous to fsys, e.g. a divided clock.
REQ-006 pm_ready  input  1  consumer accepts the current result when pm_valid and pm_ready are high in the same cycle.
REQ-007 pm_period  output  CNT_W  fsys cycles between two consecutive detected rising edges of pm_in.
REQ-008 pm_high  output  CNT_W  fsys cycles from a detected rising edge to the next detected falling edge.
REQ-009 pm_valid  output  1  pm_period and pm_high hold a result not yet accepted.
REQ-010 pm_timeout  output  1  sticky; counter saturated without a rising edge.
REQ-011 pm_overrun  output  1  sticky; a measurement completed while the previous result was still unaccepted.

Function
REQ-012 pm_in shall pass through SYNC_STAGES flops; one further flop holds the previous synchronized value for edge detection.
REQ-013 A rise is synchronized value 1 with previous value 0; a fall is the reverse; each is a single-cycle strobe, SYNC_STAGES+1 cycles after the pm_in transition.
REQ-014 FSM states: IDLE, ARMED, TIMEOUT; reset state IDLE.
REQ-015 IDLE: on rise, clear cnt to 0, clear high_seen, go to ARMED; otherwise hold.
REQ-016 ARMED: cnt increments by 1 each cycle in which no rise occurs.
REQ-017 ARMED, fall while high_seen=0: capture high_cap = cnt+1, set high_seen.
REQ-018 ARMED, rise: the completed measurement is period = cnt+1, high = high_cap; cnt clears to 0; high_seen clears; the state stays ARMED.
REQ-019 At that rise, if pm_valid=0 or pm_ready=1 in the same cycle, load pm_period/pm_high from the completed measurement and set pm_valid on the next cycle; otherwise discard it, keep the old result, and set pm_overrun.
REQ-020 A rise with no preceding fall in the period (high_seen=0) shall report pm_high = period.
REQ-021 pm_valid shall clear on the cycle after a handshake unless a new result loads in that same cycle; pm_period/pm_high shall be stable while pm_valid=1.
REQ-022 ARMED, cnt = 2^CNT_W-2 with no rise: set pm_timeout and go to TIMEOUT; cnt shall never wrap.
REQ-023 TIMEOUT: on rise, clear cnt and go to ARMED, discarding the partial measurement; pm_timeout stays set.
REQ-024 pm_timeout and pm_overrun shall clear only on reset.
REQ-025 The first rise after reset or after a timeout only arms; no result is produced until the second rise.

Reset
REQ-026 While pm_rst=1 at a fsys edge: state=IDLE, cnt=0, high_cap=0, high_seen=0, all sync flops=0, pm_period=0, pm_high=0, pm_valid=0, pm_timeout=0, pm_overrun=0.
REQ-027 Reset mid-measurement shall discard all partial and pending results.
REQ-028 After reset, a pm_in held high shall not produce a rise; a rise requires a low-to-high transition.

Structure
REQ-029 The FSM state encoding and the saturation constant shall live in a shared package used by the timing blocks.
REQ-030 The synchronizer plus edge detector shall be one sub-module, edge_sync, with outputs rise and fall and parameter SYNC_STAGES.
REQ-031 Parameters shall give CNT_W and SYNC_STAGES; no hard-coded widths.

Verification
REQ-032 pm_in from a divide-by-16 square wave, 50% duty, pm_ready=1 -> after the second rise, pm_valid pulses once per period with pm_period=16 and pm_high=8.
REQ-033 Pulse pm_in high for 3 cycles every 10 cycles, pm_ready=1 -> pm_period=10, pm_high=3.
REQ-034 Divide-by-16 input, pm_ready=0 -> first result held (16/8), pm_valid=1, pm_overrun=1 after the next rise; raise pm_ready -> pm_valid drops one cycle later, and the next result loads at the following rise.
REQ-035 CNT_W=4, pm_in rises once then stays low -> pm_timeout=1 when cnt reaches 14, state TIMEOUT; a new rise rearms, and the following rise gives a valid result with pm_timeout still 1.
REQ-036 Assert pm_rst for one cycle mid-period while pm_valid=1 -> every output is 0 next cycle; the first post-reset result needs two rises.
REQ-037 Hold pm_in high through reset release -> no result until pm_in goes low then high twice.
